// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Constants and types only; no timing or flow control of its own.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mult/multu/div/divu datapath producing a {hi,lo} result and a divide-by-zero flag.
// Zero latency; no flow control, the scheduler captures the result at its accept edge.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [2:0]  op,
    output md_res_t     res,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        sgn;

    always_comb begin
        sgn      = (op == MD_DIV);
        prod_s   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u   = {32'd0, rs} * {32'd0, rt};
        // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
        mag_a    = (sgn && rs[31]) ? -rs : rs;
        mag_b    = (sgn && rt[31]) ? -rt : rt;
        div_zero = (rt == 32'd0);
        b_safe   = div_zero ? 32'd1 : mag_b;
        q_mag    = mag_a / b_safe;
        r_mag    = mag_a % b_safe;
        res      = '0;
        case (op)
            MD_MULT:  res = md_res_t'(prod_s);
            MD_MULTU: res = md_res_t'(prod_u);
            MD_DIV, MD_DIVU: begin
                res.lo = (sgn && (rs[31] ^ rt[31])) ? -q_mag : q_mag;
                res.hi = (sgn && rs[31]) ? -r_mag : r_mag;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Owns HI/LO and sequences mult/div with fixed latency; result lands the first cycle busy is low.
// No backpressure path: stall_md holds D-stage md instructions while busy; start while busy is dropped.
module md_scheduler
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

    logic [CW-1:0] cnt;
    md_res_t       pend;
    md_res_t       arith_res;
    logic          div_zero;

    md_arith u_arith (
        .rs       (rs_val),
        .rt       (rt_val),
        .op       (md_op),
        .res      (arith_res),
        .div_zero (div_zero)
    );

    assign busy     = (cnt != '0);
    assign stall_md = d_is_md & (busy | (start & is_muldiv(md_op)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            pend <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (cnt != '0) begin
            if (cnt == CW'(1)) begin
                hi <= pend.hi;
                lo <= pend.lo;
            end
            cnt <= cnt - CW'(1);
        end else if (start) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    pend <= arith_res;
                    cnt  <= MULT_LD;
                end
                MD_DIV, MD_DIVU: begin
                    // HI/LO cannot change during RUN, so a zero divisor just re-commits them.
                    pend <= div_zero ? md_res_t'({hi, lo}) : arith_res;
                    cnt  <= DIV_LD;
                end
                MD_MTHI: hi <= rs_val;
                MD_MTLO: lo <= rs_val;
                default: ;
            endcase
        end
    end

endmodule
